pipe_stage_reg: RTL and testbench

// Parametrised elastic pipeline register for the RV32I 5-stage core. It replaces the fixed
// per-stage registers (D->E, E->M, M->W). It carries NUM_CH payload channels (pc, rs1, rs2,
// imm, ...) of DATA_W bits each, using a valid/ready handshake with a 2-entry skid buffer.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush-to-bubble and
// saturating bubble/stall performance counters.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_CH      = 4,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL  = 'h00000013,
  parameter logic [NUM_CH-1:0]  BUBBLE_MASK = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int PW = NUM_CH * DATA_W;

  function automatic logic [PW-1:0] bubble_pat();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (BUBBLE_MASK[i]) p[i*DATA_W +: DATA_W] = BUBBLE_VAL;
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic          vld_p0;
  logic [PW-1:0] main_data_p0;
  logic          skid_v;
  logic [PW-1:0] skid_data_p0;
  logic          accept;
  logic          drain;

  assign in_ready  = !skid_v;
  assign accept    = in_valid & in_ready;
  assign drain     = out_ready | !vld_p0;
  assign out_valid = vld_p0;
  assign out_data  = main_data_p0;

  // stage p0: main register; payload is forced to the bubble pattern whenever it empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      skid_v       <= 1'b0;
      main_data_p0 <= bubble_pat();
    end else if (flush) begin
      vld_p0       <= 1'b0;
      skid_v       <= 1'b0;
      main_data_p0 <= bubble_pat();
    end else if (drain) begin
      if (skid_v) begin
        vld_p0       <= 1'b1;
        main_data_p0 <= skid_data_p0;
        skid_v       <= 1'b0;
      end else if (accept) begin
        vld_p0       <= 1'b1;
        main_data_p0 <= in_data;
      end else begin
        vld_p0       <= 1'b0;
        main_data_p0 <= bubble_pat();
      end
    end else if (accept) begin
      skid_v <= 1'b1;
    end
  end

  // skid payload is only meaningful while skid_v is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (!flush && !drain && accept) skid_data_p0 <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!vld_p0)              bubble_cnt <= sat_inc(bubble_cnt);
      if (vld_p0 && !out_ready) stall_cnt  <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table plus hand-written corner sequences and a queue-model
// random run for pipe_stage_reg (BUBBLE_MASK=4'b0001, CNT_W=4).
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int PW = DW * NC;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] stall_cnt;

  int nvec  = 0;
  int nfail = 0;

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_CH(NC), .BUBBLE_VAL(32'h00000013),
    .BUBBLE_MASK(4'b0001), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [PW-1:0] BUBBLE = {96'h0, 32'h00000013};

  function automatic logic [PW-1:0] pk(input logic [31:0] v);
    return {~v, v ^ 32'hA5A5_5A5A, v + 32'd1, v};
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        eir;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl, input logic ev, input logic [31:0] ed,
                              input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.ev = ev; v.ed = ed; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [PW+1:0] act, input logic [PW+1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [PW-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [PW-1:0] q[$];
  logic          acc, xf;
  logic [PW+1:0] exp_st;

  initial begin
    // pc streaming, 3-cycle stall with A/B/C, flush with full skid, flush with transfer
    tbl[0]  = mk(1, 32'h100, 1, 0, 1, 32'h100, 1);
    tbl[1]  = mk(1, 32'h104, 1, 0, 1, 32'h104, 1);
    tbl[2]  = mk(1, 32'h108, 1, 0, 1, 32'h108, 1);
    tbl[3]  = mk(0, 32'h0,   1, 0, 0, 32'h0,   1);
    tbl[4]  = mk(1, 32'hA0,  0, 0, 1, 32'hA0,  1);
    tbl[5]  = mk(1, 32'hB0,  0, 0, 1, 32'hA0,  0);
    tbl[6]  = mk(1, 32'hC0,  0, 0, 1, 32'hA0,  0);
    tbl[7]  = mk(1, 32'hC0,  0, 0, 1, 32'hA0,  0);
    tbl[8]  = mk(1, 32'hC0,  1, 0, 1, 32'hB0,  1);
    tbl[9]  = mk(1, 32'hC0,  1, 0, 1, 32'hC0,  1);
    tbl[10] = mk(0, 32'h0,   1, 0, 0, 32'h0,   1);
    tbl[11] = mk(1, 32'hD0,  0, 0, 1, 32'hD0,  1);
    tbl[12] = mk(1, 32'hE0,  0, 0, 1, 32'hD0,  0);
    tbl[13] = mk(1, 32'hF0,  0, 1, 0, 32'h0,   1);
    tbl[14] = mk(1, 32'h60,  1, 1, 0, 32'h0,   1);
    tbl[15] = mk(0, 32'h0,   1, 0, 0, 32'h0,   1);
    tbl[16] = mk(1, 32'h70,  1, 0, 1, 32'h70,  1);
    tbl[17] = mk(0, 32'h0,   1, 1, 0, 32'h0,   1);
    tbl[18] = mk(0, 32'h0,   1, 0, 0, 32'h0,   1);

    do_reset();
    chk("reset state", {out_valid, in_ready, out_data}, {1'b0, 1'b1, BUBBLE});
    chk("reset counters", {bubble_cnt, stall_cnt}, '0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].iv, pk(tbl[i].d), tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d", i), {out_valid, in_ready, out_data},
          {tbl[i].ev, tbl[i].eir, tbl[i].ev ? pk(tbl[i].ed) : BUBBLE});
    end
    chk("bubble_cnt after table", bubble_cnt, 7);
    chk("stall_cnt after table", stall_cnt, 5);

    // async reset asserted between edges with main and skid both full
    step(1, pk(32'h200), 0, 0);
    step(1, pk(32'h204), 0, 0);
    chk("skid full before rst", {out_valid, in_ready, out_data}, {1'b1, 1'b0, pk(32'h200)});
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst outputs", {out_valid, in_ready, out_data}, {1'b0, 1'b1, BUBBLE});
    chk("async rst counters", {bubble_cnt, stall_cnt}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, '0, 1, 0);
    chk("held entries lost", {out_valid, in_ready, out_data}, {1'b0, 1'b1, BUBBLE});

    // idle saturation of the 4-bit bubble counter
    do_reset();
    for (int i = 0; i < 15; i++) step(0, '0, 0, 0);
    chk("bubble_cnt reaches 15", bubble_cnt, 15);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0);
    chk("bubble_cnt sticks at 15", bubble_cnt, 15);
    chk("stall_cnt idle", stall_cnt, 0);

    // random traffic against a queue model
    do_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      acc = in_valid & in_ready;
      xf  = out_valid & out_ready;
      @(posedge clk);
      if (xf && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(in_data);
      #1;
      if (q.size() > 0) exp_st = {1'b1, (q.size() < 2), q[0]};
      else              exp_st = {1'b0, 1'b1, BUBBLE};
      chk($sformatf("rand cycle %0d", c), {out_valid, in_ready, out_data}, exp_st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
